// File: rtl/axis_pkt_fifo_if.sv
// AXI-Stream handshake bundle used on both sides of axis_pkt_fifo.
// master drives the payload and valid; slave drives ready.
interface axis_pkt_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo.sv
// Single-clock AXI-Stream FIFO with a registered output stage, level/threshold flags
// and an optional store-and-forward mode that drops packets too large to ever fit.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_PASS | normal operation, accepted words are stored
// ST_DROP | oversized packet in flight: words accepted and discarded to tlast
module axis_pkt_fifo #(
  parameter int DATA_WIDTH  = 16,
  parameter int USER_WIDTH  = 1,
  parameter int FIFO_LEN    = 16,
  parameter int PACKET_MODE = 0,
  parameter int AF_THR      = FIFO_LEN - 2,
  parameter int AE_THR      = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  axis_pkt_fifo_if.slave            s_axis_in,
  axis_pkt_fifo_if.master           m_axis_out,
  output logic [$clog2(FIFO_LEN):0] level_o,
  output logic                      almost_full_o,
  output logic                      almost_empty_o,
  output logic                      drop_o
);
  localparam int PW = $clog2(FIFO_LEN);
  localparam int WW = DATA_WIDTH + USER_WIDTH + 1;

  typedef logic [PW:0] ptr_t;
  typedef enum logic {ST_PASS, ST_DROP} state_t;

  localparam ptr_t AF_LVL = ptr_t'(AF_THR);
  localparam ptr_t AE_LVL = ptr_t'(AE_THR);

  state_t  state_q, state_d;
  ptr_t    wr_ptr, commit_ptr, rd_ptr, avail_ptr, mem_level;
  logic    full, in_fire, store, load, wr_rewind, drop_d;
  logic [WW-1:0] mem [FIFO_LEN];

  assign mem_level = wr_ptr - rd_ptr;
  assign full      = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);

  assign s_axis_in.tready = (state_q == ST_DROP) || !full;
  assign in_fire          = s_axis_in.tvalid && s_axis_in.tready;
  assign store            = in_fire && (state_q == ST_PASS);

  // In store-and-forward mode the reader only sees words up to the last committed tlast.
  assign avail_ptr = (PACKET_MODE != 0) ? commit_ptr : wr_ptr;
  assign load      = (avail_ptr != rd_ptr) && (!m_axis_out.tvalid || m_axis_out.tready);

  always_comb begin
    state_d   = state_q;
    wr_rewind = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      ST_PASS: begin
        // Full with nothing committed means the current packet can never complete.
        if ((PACKET_MODE != 0) && full && (commit_ptr == rd_ptr) && s_axis_in.tvalid) begin
          state_d   = ST_DROP;
          wr_rewind = 1'b1;
        end
      end
      ST_DROP: begin
        if (in_fire && s_axis_in.tlast) begin
          state_d = ST_PASS;
          drop_d  = 1'b1;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= ST_PASS;
      drop_o     <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
    end else begin
      state_q <= state_d;
      drop_o  <= drop_d;
      if (wr_rewind)
        wr_ptr <= commit_ptr;
      else if (store)
        wr_ptr <= wr_ptr + ptr_t'(1);
      if (store && s_axis_in.tlast)
        commit_ptr <= wr_ptr + ptr_t'(1);
      if (load)
        rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (store)
      mem[wr_ptr[PW-1:0]] <= {s_axis_in.tuser, s_axis_in.tlast, s_axis_in.tdata};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      m_axis_out.tvalid <= 1'b0;
      m_axis_out.tdata  <= '0;
      m_axis_out.tuser  <= '0;
      m_axis_out.tlast  <= 1'b0;
    end else if (load) begin
      {m_axis_out.tuser, m_axis_out.tlast, m_axis_out.tdata} <= mem[rd_ptr[PW-1:0]];
      m_axis_out.tvalid <= 1'b1;
    end else if (m_axis_out.tready) begin
      m_axis_out.tvalid <= 1'b0;
    end
  end

  assign level_o        = mem_level + ptr_t'(m_axis_out.tvalid);
  assign almost_full_o  = (mem_level >= AF_LVL);
  assign almost_empty_o = (mem_level <= AE_LVL);
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench: cut-through FIFO (16 deep) and store-and-forward FIFO (8 deep)
// side by side, sharing clock and reset.
module tb_axis_pkt_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  axis_pkt_fifo_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) ct_in ();
  axis_pkt_fifo_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) ct_out ();
  axis_pkt_fifo_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) pk_in ();
  axis_pkt_fifo_if #(.DATA_WIDTH(16), .USER_WIDTH(1)) pk_out ();

  logic [4:0] ct_level;
  logic       ct_af, ct_ae, ct_drop;
  logic [3:0] pk_level;
  logic       pk_af, pk_ae, pk_drop;

  axis_pkt_fifo #(.DATA_WIDTH(16), .USER_WIDTH(1), .FIFO_LEN(16), .PACKET_MODE(0),
                  .AF_THR(14), .AE_THR(2)) u_ct (
    .clk_i(clk), .reset_ni(rst_n), .s_axis_in(ct_in), .m_axis_out(ct_out),
    .level_o(ct_level), .almost_full_o(ct_af), .almost_empty_o(ct_ae), .drop_o(ct_drop));

  axis_pkt_fifo #(.DATA_WIDTH(16), .USER_WIDTH(1), .FIFO_LEN(8), .PACKET_MODE(1),
                  .AF_THR(6), .AE_THR(2)) u_pk (
    .clk_i(clk), .reset_ni(rst_n), .s_axis_in(pk_in), .m_axis_out(pk_out),
    .level_o(pk_level), .almost_full_o(pk_af), .almost_empty_o(pk_ae), .drop_o(pk_drop));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams nwords through the cut-through FIFO, scoreboarding every output word.
  task automatic run_stream(input int nwords, input int base, input bit rnd, output int cyc);
    logic [17:0] q[$];
    logic [17:0] w, o;
    int sent = 0;
    int got  = 0;
    cyc = 0;
    while ((sent < nwords || got < nwords) && cyc < 2000) begin
      ct_in.tvalid  = (sent < nwords);
      ct_in.tdata   = 16'(base + sent);
      ct_in.tlast   = (sent % 7 == 6);
      ct_in.tuser   = 1'(sent % 3 == 0);
      ct_out.tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ct_out.tvalid && ct_out.tready) begin
        o = {ct_out.tuser, ct_out.tlast, ct_out.tdata};
        w = (q.size() > 0) ? q.pop_front() : 18'bx;
        check("stream_word", 32'(o), 32'(w));
        got++;
      end
      if (ct_in.tvalid && ct_in.tready) begin
        q.push_back({ct_in.tuser, ct_in.tlast, ct_in.tdata});
        sent++;
      end
      tick();
      cyc++;
    end
    ct_in.tvalid = 1'b0;
    check("stream_words_out", 32'(got), 32'(nwords));
    check("stream_leftover", 32'(q.size()), 32'd0);
  endtask

  task automatic pk_send(input logic [15:0] d, input logic last);
    logic acc;
    acc = 1'b0;
    pk_in.tvalid = 1'b1;
    pk_in.tdata  = d;
    pk_in.tlast  = last;
    pk_in.tuser  = 1'b0;
    for (int c = 0; c < 8 && !acc; c++) begin
      acc = pk_in.tready;
      tick();
    end
    check("pk_accept_timeout", 32'(acc), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    ct_in.tvalid = 0; ct_in.tdata = 0; ct_in.tlast = 0; ct_in.tuser = 0; ct_out.tready = 0;
    pk_in.tvalid = 0; pk_in.tdata = 0; pk_in.tlast = 0; pk_in.tuser = 0; pk_out.tready = 0;

    // reset state
    rst_n = 1'b0;
    #12;
    check("rst_ct_tready_in", 32'(ct_in.tready), 32'd1);
    check("rst_ct_tvalid_out", 32'(ct_out.tvalid), 32'd0);
    check("rst_ct_level", 32'(ct_level), 32'd0);
    check("rst_ct_ae", 32'(ct_ae), 32'd1);
    check("rst_ct_af", 32'(ct_af), 32'd0);
    check("rst_ct_drop", 32'(ct_drop), 32'd0);
    check("rst_pk_tready_in", 32'(pk_in.tready), 32'd1);
    check("rst_pk_drop", 32'(pk_drop), 32'd0);
    rst_n = 1'b1;
    tick();

    // fill with output stalled: first word moves into the output register
    for (int k = 1; k <= 17; k++) begin
      ct_in.tvalid = 1'b1;
      ct_in.tdata  = 16'(k - 1);
      ct_in.tlast  = (k - 1 == 15);
      ct_in.tuser  = 1'((k - 1) % 2);
      tick();
      check("fill_level", 32'(ct_level), 32'(k));
      check("fill_af", 32'(ct_af), 32'(k >= 15));
      check("fill_tready_in", 32'(ct_in.tready), 32'(k < 17));
    end
    check("fill_out_valid", 32'(ct_out.tvalid), 32'd1);
    check("fill_out_data", 32'(ct_out.tdata), 32'd0);

    // full: extra word must not be accepted
    ct_in.tdata = 16'h0099;
    tick();
    tick();
    check("full_level_hold", 32'(ct_level), 32'd17);
    check("full_out_hold", 32'(ct_out.tdata), 32'd0);

    // drain
    ct_in.tvalid  = 1'b0;
    ct_out.tready = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      check("drain_valid", 32'(ct_out.tvalid), 32'd1);
      check("drain_data", 32'(ct_out.tdata), 32'(j));
      check("drain_last", 32'(ct_out.tlast), 32'(j == 15));
      check("drain_user", 32'(ct_out.tuser), 32'(j % 2));
      check("drain_ae", 32'(ct_ae), 32'(j >= 14));
      tick();
    end
    check("drain_empty_valid", 32'(ct_out.tvalid), 32'd0);
    check("drain_empty_level", 32'(ct_level), 32'd0);

    // simultaneous in/out with random output backpressure
    run_stream(100, 32'h1000, 1'b1, cyc);

    // store-and-forward: nothing visible until the packet is committed
    pk_out.tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pk_in.tvalid = 1'b1;
      pk_in.tdata  = 16'(16'h50 + i);
      pk_in.tlast  = (i == 4);
      pk_in.tuser  = 1'b0;
      tick();
      check("pk_hold_valid", 32'(pk_out.tvalid), 32'd0);
    end
    pk_in.tvalid = 1'b0;
    check("pk_level_committed", 32'(pk_level), 32'd5);
    tick();
    check("pk_first_valid", 32'(pk_out.tvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("pk_read_data", 32'(pk_out.tdata), 32'(16'h50 + i));
      check("pk_read_last", 32'(pk_out.tlast), 32'(i == 4));
      tick();
    end
    check("pk_read_done", 32'(pk_out.tvalid), 32'd0);

    // oversized packet (12 words into 8-deep) is dropped
    for (int i = 0; i < 12; i++) begin
      pk_send(16'(16'h60 + i), (i == 11));
      check("pk_big_no_out", 32'(pk_out.tvalid), 32'd0);
      check("pk_big_drop", 32'(pk_drop), 32'(i == 11));
    end
    pk_in.tvalid = 1'b0;
    check("pk_big_level", 32'(pk_level), 32'd0);
    tick();
    check("pk_drop_pulse_end", 32'(pk_drop), 32'd0);
    check("pk_big_no_out2", 32'(pk_out.tvalid), 32'd0);

    // following small packet passes intact
    for (int i = 0; i < 3; i++) pk_send(16'(16'hB0 + i), (i == 2));
    pk_in.tvalid = 1'b0;
    check("pk_small_hold", 32'(pk_out.tvalid), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("pk_small_valid", 32'(pk_out.tvalid), 32'd1);
      check("pk_small_data", 32'(pk_out.tdata), 32'(16'hB0 + i));
      check("pk_small_last", 32'(pk_out.tlast), 32'(i == 2));
      tick();
    end
    check("pk_small_done", 32'(pk_out.tvalid), 32'd0);

    // asynchronous reset mid-packet with output valid
    ct_out.tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ct_in.tvalid = 1'b1;
      ct_in.tdata  = 16'(16'h70 + i);
      ct_in.tlast  = 1'b0;
      tick();
    end
    check("prerst_valid", 32'(ct_out.tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ct_out.tvalid), 32'd0);
    check("arst_data", 32'(ct_out.tdata), 32'd0);
    check("arst_level", 32'(ct_level), 32'd0);
    check("arst_tready_in", 32'(ct_in.tready), 32'd1);
    ct_in.tvalid = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();

    // post-reset stream long enough to wrap the pointers, at full rate
    run_stream(40, 32'h2000, 1'b0, cyc);
    check("wrap_throughput_cycles", 32'(cyc), 32'd42);
    check("wrap_final_level", 32'(ct_level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
